kulisch_dot_accumulator: RTL and testbench

- Sequential accumulator stage directly downstream of the float multiply-add datapath.
- Owns the Kulisch accumulator register and drives it back as the multiply-add `accIn` operand.
- Captures the multiply-add `accOut` sum for each accepted product.
- At the last element of a vector, freezes the finished dot-product sum in a result register and presents it on a valid/ready output for the downstream accumulator-to-float conversion stage.

---
 rtl/kulisch_dot_accumulator.sv | 76 +++++++
 tb/tb_kulisch_dot_accumulator.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/kulisch_dot_accumulator.sv
// Kulisch accumulator stage behind the float multiply-add datapath.
// Holds the running sum and hands each finished dot product downstream.
module kulisch_dot_accumulator #(
  parameter int ACC_NON_FRAC = 17,
  parameter int ACC_FRAC     = 11,
  parameter int CNT_W        = 16,
  localparam int ACC_W       = ACC_NON_FRAC + ACC_FRAC
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inValid,
  input  logic             inLast,
  output logic             inReady,
  input  logic [ACC_W-1:0] sumIn,
  input  logic             sumInOverflow,
  output logic [ACC_W-1:0] accFeed,
  input  logic             clear,
  output logic             outValid,
  input  logic             outReady,
  output logic [ACC_W-1:0] outAcc,
  output logic             outOverflow,
  output logic [CNT_W-1:0] outCount
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic             accOvf;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntInc;
  logic             accept;
  logic             take;

  assign accFeed  = acc;
  assign outValid = (state == HOLD);
  assign inReady  = (state == ACCUM) | outReady;
  assign accept   = inValid & inReady;
  // A clear consumes the element but throws it away, including a last one.
  assign take     = accept & ~clear;
  assign cntInc   = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ACCUM;
      acc         <= '0;
      accOvf      <= 1'b0;
      cnt         <= '0;
      outAcc      <= '0;
      outOverflow <= 1'b0;
      outCount    <= '0;
    end else begin
      if (state == HOLD && outReady)
        state <= ACCUM;

      if (clear) begin
        acc    <= '0;
        accOvf <= 1'b0;
        cnt    <= '0;
      end else if (take && !inLast) begin
        acc    <= sumIn;
        accOvf <= accOvf | sumInOverflow;
        cnt    <= cntInc;
      end else if (take && inLast) begin
        outAcc      <= sumIn;
        outOverflow <= accOvf | sumInOverflow;
        outCount    <= cntInc;
        acc         <= '0;
        accOvf      <= 1'b0;
        cnt         <= '0;
        state       <= HOLD;
      end
    end
  end

endmodule

// File: tb/tb_kulisch_dot_accumulator.sv
// Bench for kulisch_dot_accumulator: directed scenarios plus random traffic
// checked against a transaction-level model of the dot-product stream.
module tb_kulisch_dot_accumulator;

  localparam int NF   = 17;
  localparam int FR   = 11;
  localparam int CW   = 4;
  localparam int AW   = NF + FR;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          inValid, inLast, inReady;
  logic [AW-1:0] sumIn, accFeed, prod;
  logic          sumInOverflow, clear;
  logic          outValid, outReady, outOverflow;
  logic [AW-1:0] outAcc;
  logic [CW-1:0] outCount;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Model state: running partial sum and the pending finished result.
  logic [AW-1:0] m_acc, m_res_acc;
  bit            m_ovf, m_res_ovf, m_hold;
  int unsigned   m_cnt, m_res_cnt;

  always #5 clock = ~clock;

  // Stand-in for the multiply-add: sum = accumulator + product.
  assign sumIn = accFeed + prod;

  kulisch_dot_accumulator #(.ACC_NON_FRAC(NF), .ACC_FRAC(FR), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .inValid(inValid), .inLast(inLast), .inReady(inReady),
    .sumIn(sumIn), .sumInOverflow(sumInOverflow), .accFeed(accFeed),
    .clear(clear),
    .outValid(outValid), .outReady(outReady),
    .outAcc(outAcc), .outOverflow(outOverflow), .outCount(outCount)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = '0; m_ovf = 0; m_cnt = 0;
    m_res_acc = '0; m_res_ovf = 0; m_res_cnt = 0; m_hold = 0;
  endtask

  task automatic check_outputs();
    chk("accFeed", 64'(accFeed), 64'(m_acc));
    chk("outValid", 64'(outValid), 64'(m_hold));
    chk("outAcc", 64'(outAcc), 64'(m_res_acc));
    chk("outOverflow", 64'(outOverflow), 64'(m_res_ovf));
    chk("outCount", 64'(outCount), 64'(m_res_cnt));
  endtask

  // One clock of stimulus; entered and left shortly after a rising edge.
  task automatic step(input bit v, input bit l, input logic [AW-1:0] p,
                      input bit o, input bit c, input bit r);
    bit rdy, acc_ok;
    logic [AW-1:0] s;
    int unsigned nc;
    inValid = v; inLast = l; prod = p; sumInOverflow = o; clear = c; outReady = r;
    #1;
    rdy = !m_hold || r;
    chk("inReady", 64'(inReady), 64'(rdy));
    acc_ok = v && rdy;
    if (m_hold && r) m_hold = 0;
    if (c) begin
      m_acc = '0; m_ovf = 0; m_cnt = 0;
    end else if (acc_ok) begin
      s  = m_acc + p;
      nc = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      if (l) begin
        m_res_acc = s; m_res_ovf = m_ovf | o; m_res_cnt = nc; m_hold = 1;
        m_acc = '0; m_ovf = 0; m_cnt = 0;
      end else begin
        m_acc = s; m_ovf = m_ovf | o; m_cnt = nc;
      end
    end
    @(posedge clock); #1;
    check_outputs();
  endtask

  task automatic idle(input bit r);
    step(0, 0, '0, 0, 0, r);
  endtask

  initial begin
    inValid = 0; inLast = 0; prod = '0; sumInOverflow = 0; clear = 0; outReady = 0;
    reset = 1;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 0;
    idle(1);
    chk("rst_inReady", 64'(inReady), 64'd1);

    // Three elements of 1.0.
    step(1, 0, 28'h800, 0, 0, 1);
    chk("vec3_feed1", 64'(accFeed), 64'h800);
    step(1, 0, 28'h800, 0, 0, 1);
    chk("vec3_feed2", 64'(accFeed), 64'h1000);
    step(1, 1, 28'h800, 0, 0, 1);
    chk("vec3_valid", 64'(outValid), 64'd1);
    chk("vec3_acc", 64'(outAcc), 64'h1800);
    chk("vec3_cnt", 64'(outCount), 64'd3);
    idle(1);

    // Same vector, then downstream stalls while an element waits.
    step(1, 0, 28'h800, 0, 0, 1);
    step(1, 0, 28'h800, 0, 0, 1);
    step(1, 1, 28'h800, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 28'h800, 0, 0, 0);
      chk("stall_acc", 64'(outAcc), 64'h1800);
      chk("stall_feed", 64'(accFeed), 64'h0);
    end
    step(1, 0, 28'h800, 0, 0, 1);
    chk("release_valid", 64'(outValid), 64'd0);
    chk("release_feed", 64'(accFeed), 64'h800);
    step(0, 0, '0, 0, 1, 1);
    chk("clear_feed", 64'(accFeed), 64'h0);

    // Back-to-back single-element vectors.
    step(1, 1, 28'h800, 0, 0, 1);
    chk("b2b_acc1", 64'(outAcc), 64'h800);
    step(1, 1, 28'hFFFFC00, 0, 0, 1);
    chk("b2b_valid", 64'(outValid), 64'd1);
    chk("b2b_acc2", 64'(outAcc), 64'hFFFFC00);
    chk("b2b_cnt", 64'(outCount), 64'd1);

    // Overflow is sticky within a vector only.
    step(1, 0, 28'h800, 1, 0, 1);
    step(1, 1, 28'h800, 0, 0, 1);
    chk("ovf_set", 64'(outOverflow), 64'd1);
    step(1, 0, 28'h800, 0, 0, 1);
    step(1, 1, 28'h800, 0, 0, 1);
    chk("ovf_clr", 64'(outOverflow), 64'd0);

    // Clear mid-vector, then a fresh single element.
    step(1, 0, 28'h800, 0, 0, 1);
    step(1, 0, 28'h800, 0, 0, 1);
    chk("pre_clear", 64'(accFeed), 64'h1000);
    step(1, 1, 28'h800, 0, 1, 1);
    chk("post_clear", 64'(accFeed), 64'h0);
    step(1, 1, 28'h800, 0, 0, 1);
    chk("clear_acc", 64'(outAcc), 64'h800);
    chk("clear_cnt", 64'(outCount), 64'd1);

    // Saturating element count.
    for (int i = 0; i < CMAX + 4; i++)
      step(1, (i == CMAX + 3), 28'h1, 0, 0, 1);
    chk("sat_cnt", 64'(outCount), 64'(CMAX));

    // Asynchronous reset mid-vector.
    step(1, 0, 28'h800, 0, 0, 1);
    step(1, 0, 28'h800, 0, 0, 1);
    reset = 1;
    #1;
    chk("arst_feed", 64'(accFeed), 64'h0);
    chk("arst_valid", 64'(outValid), 64'd0);
    model_reset();
    @(posedge clock); #1;
    reset = 0;
    idle(1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] p;
      p = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($signed(12'($urandom)));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, p,
           $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
